// File: rtl/arat_pkg.sv
// Shared types and sizing for the architectural RAT (committed Areg->Preg map).
// Optional free-list reclaim outputs are enabled by defining ARAT_FREE_RECLAIM_EN.
package arat_pkg;
  localparam int AREG_NUM = 8;
  localparam int PREG_W   = 5;
  localparam int COMMIT_W = 3;
  localparam int AREG_W   = $clog2(AREG_NUM);

  typedef logic [AREG_W-1:0] areg_t;
  typedef logic [PREG_W-1:0] preg_t;
  typedef logic [AREG_NUM-1:0][PREG_W-1:0] map_t;

  typedef enum logic {RUN, RECOVER} arat_state_e;
endpackage

// File: rtl/arat_multi_commit_if.sv
// ROB-commit / RAT-recovery / free-list bundle around the architectural RAT.
// master = ROB/RAT side driving commits, slave = the ARAT itself.
interface arat_multi_commit_if;
  import arat_pkg::*;

  logic [COMMIT_W-1:0]             commit_vld;
  logic [COMMIT_W-1:0]             RegWr;
  logic [COMMIT_W-1:0]             exp;
  logic [COMMIT_W-1:0][AREG_W-1:0] Aw_commit;
  logic [COMMIT_W-1:0][PREG_W-1:0] Pw_commit;
  logic                            commit_rdy;
  map_t                            ARAT_P_list;
  logic                            recover_vld;
  logic                            recover_rdy;
  logic [COMMIT_W-1:0]             free_vld;
  logic [COMMIT_W-1:0][PREG_W-1:0] free_P;

  modport master (
    output commit_vld, RegWr, exp, Aw_commit, Pw_commit, recover_rdy,
    input  commit_rdy, ARAT_P_list, recover_vld, free_vld, free_P
  );

  modport slave (
    input  commit_vld, RegWr, exp, Aw_commit, Pw_commit, recover_rdy,
    output commit_rdy, ARAT_P_list, recover_vld, free_vld, free_P
  );
endinterface

// File: rtl/arat_lane_resolve.sv
// Combinational commit-group resolution: kill mask, effective writes, next map, old-Preg bypass.
// Old-Preg outputs exist only when ARAT_FREE_RECLAIM_EN is defined.
module arat_lane_resolve
  import arat_pkg::*;
(
  input  logic [COMMIT_W-1:0]             commit_vld,
  input  logic [COMMIT_W-1:0]             RegWr,
  input  logic [COMMIT_W-1:0]             exp,
  input  logic [COMMIT_W-1:0][AREG_W-1:0] Aw,
  input  logic [COMMIT_W-1:0][PREG_W-1:0] Pw,
  input  map_t                            map_cur,
  output map_t                            map_nxt,
  output logic [COMMIT_W-1:0]             wr_en,
`ifdef ARAT_FREE_RECLAIM_EN
  output logic [COMMIT_W-1:0][PREG_W-1:0] old_p,
`endif
  output logic                            any_exp
);
  logic killed;
  logic eff;

  assign any_exp = |(commit_vld & exp);

  // Walk lanes oldest-first so later writes override earlier ones, and the
  // partially updated map already holds each lane's intra-group bypass value.
  always_comb begin
    killed  = 1'b0;
    eff     = 1'b0;
    wr_en   = '0;
    map_nxt = map_cur;
`ifdef ARAT_FREE_RECLAIM_EN
    old_p   = '0;
`endif
    for (int k = 0; k < COMMIT_W; k++) begin
      eff      = commit_vld[k] & ~exp[k] & ~killed;
      wr_en[k] = eff & RegWr[k];
      if (commit_vld[k] & exp[k])
        killed = 1'b1;
`ifdef ARAT_FREE_RECLAIM_EN
      old_p[k] = map_nxt[Aw[k]];
`endif
      if (wr_en[k])
        map_nxt[Aw[k]] = Pw[k];
    end
  end
endmodule

// File: rtl/arat_multi_commit.sv
// Architectural RAT: applies up to COMMIT_W in-order commits per cycle, freezes a recovery snapshot on exception.
// ARAT_FREE_RECLAIM_EN enables registered per-lane reclaim of displaced Pregs.
module arat_multi_commit
  import arat_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst,
  arat_multi_commit_if.slave     bus
);
  arat_state_e         state, state_nxt;
  map_t                arat_map, map_nxt;
  logic [COMMIT_W-1:0] wr_en;
  logic                any_exp;
  logic                recover_q;
`ifdef ARAT_FREE_RECLAIM_EN
  logic [COMMIT_W-1:0][PREG_W-1:0] old_p;
  logic [COMMIT_W-1:0]             free_vld_q;
  logic [COMMIT_W-1:0][PREG_W-1:0] free_p_q;
`endif

  arat_lane_resolve u_resolve (
    .commit_vld (bus.commit_vld),
    .RegWr      (bus.RegWr),
    .exp        (bus.exp),
    .Aw         (bus.Aw_commit),
    .Pw         (bus.Pw_commit),
    .map_cur    (arat_map),
    .map_nxt    (map_nxt),
    .wr_en      (wr_en),
`ifdef ARAT_FREE_RECLAIM_EN
    .old_p      (old_p),
`endif
    .any_exp    (any_exp)
  );

  always_comb begin
    state_nxt = state;
    case (state)
      RUN:     if (any_exp) state_nxt = RECOVER;
      RECOVER: if (bus.recover_rdy) state_nxt = RUN;
      default: state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= RUN;
      recover_q <= 1'b0;
      for (int i = 0; i < AREG_NUM; i++)
        arat_map[i] <= preg_t'(i);
    end else begin
      state     <= state_nxt;
      recover_q <= (state_nxt == RECOVER);
      if (state == RUN)
        arat_map <= map_nxt;
    end
  end

`ifdef ARAT_FREE_RECLAIM_EN
  // Reclaim is reported on the same edge the map absorbs the write.
  always_ff @(posedge clk) begin
    if (!rst) begin
      free_vld_q <= '0;
      free_p_q   <= '0;
    end else if (state == RUN) begin
      free_vld_q <= wr_en;
      free_p_q   <= old_p;
    end else begin
      free_vld_q <= '0;
    end
  end
  assign bus.free_vld = free_vld_q;
  assign bus.free_P   = free_p_q;
`else
  assign bus.free_vld = '0;
  assign bus.free_P   = '0;
`endif

  assign bus.commit_rdy  = (state == RUN);
  assign bus.recover_vld = recover_q;
  assign bus.ARAT_P_list = arat_map;
endmodule

// File: tb/tb_arat_multi_commit.sv
// Directed bench for arat_multi_commit: commits, youngest-wins, exception kill, recovery handshake, reset.
module tb_arat_multi_commit;
  import arat_pkg::*;

`ifdef ARAT_FREE_RECLAIM_EN
  localparam bit RECLAIM = 1'b1;
`else
  localparam bit RECLAIM = 1'b0;
`endif

  logic clk;
  logic rst;
  int   total;
  int   bad;
  map_t em;

  arat_multi_commit_if bus ();

  arat_multi_commit dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    total++;
    assert (obs === expv)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic clr();
    bus.commit_vld  = '0;
    bus.RegWr       = '0;
    bus.exp         = '0;
    bus.Aw_commit   = '0;
    bus.Pw_commit   = '0;
    bus.recover_rdy = 1'b0;
  endtask

  task automatic lane(input int k, input logic wr, input logic ex, input int aw, input int pw);
    bus.commit_vld[k] = 1'b1;
    bus.RegWr[k]      = wr;
    bus.exp[k]        = ex;
    bus.Aw_commit[k]  = areg_t'(aw);
    bus.Pw_commit[k]  = preg_t'(pw);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic ident();
    for (int i = 0; i < AREG_NUM; i++) em[i] = preg_t'(i);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    clr();
    ident();

    // Reset
    step(); step();
    rst = 1'b1;
    chk("reset_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("reset_recover_vld", 64'(bus.recover_vld), 64'd0);
    chk("reset_commit_rdy", 64'(bus.commit_rdy), 64'd1);
    chk("reset_free_vld", 64'(bus.free_vld), 64'd0);

    // Three independent writes
    lane(0, 1'b1, 1'b0, 1, 9);
    lane(1, 1'b1, 1'b0, 2, 10);
    lane(2, 1'b1, 1'b0, 3, 11);
    step();
    clr();
    em[1] = 5'd9; em[2] = 5'd10; em[3] = 5'd11;
    chk("three_wr_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("three_wr_free_vld", 64'(bus.free_vld), RECLAIM ? 64'h7 : 64'h0);
    chk("three_wr_free_P", 64'(bus.free_P), RECLAIM ? 64'({5'd3, 5'd2, 5'd1}) : 64'h0);
    step();
    chk("idle_free_vld", 64'(bus.free_vld), 64'd0);
    chk("idle_map", 64'(bus.ARAT_P_list), 64'(em));

    // Same Aw on lanes 0 and 2: youngest wins, lane 2 reclaims lane 0's Preg
    lane(0, 1'b1, 1'b0, 4, 12);
    lane(1, 1'b1, 1'b0, 0, 16);
    lane(2, 1'b1, 1'b0, 4, 13);
    step();
    clr();
    em[4] = 5'd13; em[0] = 5'd16;
    chk("dup_aw_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("dup_aw_free_P", 64'(bus.free_P), RECLAIM ? 64'({5'd12, 5'd0, 5'd4}) : 64'h0);

    // Exception on lane 1: lane 0 commits, lanes 1 and 2 killed
    lane(0, 1'b1, 1'b0, 5, 14);
    lane(1, 1'b1, 1'b1, 7, 17);
    lane(2, 1'b1, 1'b0, 6, 15);
    step();
    clr();
    em[5] = 5'd14;
    chk("exp_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("exp_recover_vld", 64'(bus.recover_vld), 64'd1);
    chk("exp_commit_rdy", 64'(bus.commit_rdy), 64'd0);
    chk("exp_free_vld", 64'(bus.free_vld), RECLAIM ? 64'h1 : 64'h0);
    chk("exp_free_P0", 64'(bus.free_P[0]), RECLAIM ? 64'd5 : 64'd0);

    // RECOVER holds: commits ignored while recover_rdy is low
    for (int c = 0; c < 3; c++) begin
      for (int k = 0; k < COMMIT_W; k++) lane(k, 1'b1, 1'b0, 7, 20);
      bus.recover_rdy = 1'b0;
      step();
      chk("hold_map", 64'(bus.ARAT_P_list), 64'(em));
      chk("hold_recover_vld", 64'(bus.recover_vld), 64'd1);
      chk("hold_free_vld", 64'(bus.free_vld), 64'd0);
    end
    bus.recover_rdy = 1'b1;
    step();
    clr();
    chk("release_recover_vld", 64'(bus.recover_vld), 64'd0);
    chk("release_commit_rdy", 64'(bus.commit_rdy), 64'd1);
    chk("release_map", 64'(bus.ARAT_P_list), 64'(em));

    // Back in RUN: recover_rdy ignored; non-writing lane leaves map alone
    bus.recover_rdy = 1'b1;
    lane(0, 1'b1, 1'b0, 7, 20);
    lane(1, 1'b0, 1'b0, 2, 22);
    step();
    clr();
    em[7] = 5'd20;
    chk("run_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("run_recover_vld", 64'(bus.recover_vld), 64'd0);
    chk("run_free_vld", 64'(bus.free_vld), RECLAIM ? 64'h1 : 64'h0);
    chk("run_free_P0", 64'(bus.free_P[0]), RECLAIM ? 64'd7 : 64'd0);

    // Exception on lane 0 kills everything younger
    lane(0, 1'b1, 1'b1, 2, 23);
    lane(1, 1'b1, 1'b0, 1, 21);
    step();
    clr();
    chk("exp0_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("exp0_recover_vld", 64'(bus.recover_vld), 64'd1);
    chk("exp0_free_vld", 64'(bus.free_vld), 64'd0);

    // Reset while in RECOVER
    rst = 1'b0;
    step();
    rst = 1'b1;
    ident();
    chk("rst_rec_map", 64'(bus.ARAT_P_list), 64'(em));
    chk("rst_rec_recover_vld", 64'(bus.recover_vld), 64'd0);
    chk("rst_rec_commit_rdy", 64'(bus.commit_rdy), 64'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
